// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave front end: pin synchronisers, command decode, read serialiser.
// Define SPI_FE_AUTOINC_EN for burst (auto-increment) frames.
module spi_cmd_frontend #(
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA,
      DONE
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sq, sclk_sq, mosi_sq, vld_q;
   logic                   cs_prev_q, sclk_prev_q, armed_q;

   logic                   cs_s, sclk_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, byte_done;
   logic [DATA_W-1:0]      byte_in;

   state_t                 state_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [DATA_W-2:0]      sin_q;
   logic [DATA_W-1:0]      sout_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   rd_pend_q, wdone_q;
   logic                   wr_en_q, rd_req_q, err_q;
   logic [ADDR_W-1:0]      wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0]      wr_data_q;

   // vld_q marks when the sync chains hold real pin samples, not reset values
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_sq       <= '1;
         sclk_sq     <= '0;
         mosi_sq     <= '0;
         vld_q       <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         cs_sq       <= {cs_sq[SYNC_STAGES-2:0], cs};
         sclk_sq     <= {sclk_sq[SYNC_STAGES-2:0], sclk};
         mosi_sq     <= {mosi_sq[SYNC_STAGES-2:0], mosi};
         vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
         if (vld_q[SYNC_STAGES-1] && cs_s)
            armed_q <= 1'b1;
      end
   end

   assign cs_s      = cs_sq[SYNC_STAGES-1];
   assign sclk_s    = sclk_sq[SYNC_STAGES-1];
   assign mosi_s    = mosi_sq[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign byte_in   = {sin_q, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         sin_q     <= '0;
         sout_q    <= '0;
         addr_q    <= '0;
         rd_pend_q <= 1'b0;
         wdone_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_req_q  <= 1'b0;
         err_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_req_q  <= 1'b0;
         err_q     <= 1'b0;
         rd_pend_q <= rd_req_q;
         if (state_q == IDLE) begin
            bit_cnt_q <= '0;
            wdone_q   <= 1'b0;
            if (armed_q && !cs_s)
               state_q <= CMD;
         end else if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sin_q     <= '0;
            sout_q    <= '0;
            wdone_q   <= 1'b0;
            err_q     <= (bit_cnt_q != '0) ||
                         (state_q == WDATA && !wdone_q);
         end else begin
            if (sclk_rise) begin
               sin_q     <= byte_in[DATA_W-2:0];
               bit_cnt_q <= (bit_cnt_q == LAST) ? '0 : bit_cnt_q + 1'b1;
            end
            if (state_q == RDATA && sclk_fall && bit_cnt_q != '0)
               sout_q <= sout_q << 1;
            if (state_q == RDATA && rd_pend_q)
               sout_q <= rd_data;
            if (byte_done) begin
               unique case (state_q)
                  CMD: begin
                     addr_q <= byte_in[ADDR_W-1:0];
                     if (byte_in[DATA_W-1]) begin
                        state_q <= WDATA;
                     end else begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= byte_in[ADDR_W-1:0];
                        state_q   <= RDATA;
                     end
                  end
                  WDATA: begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= addr_q;
                     wr_data_q <= byte_in;
`ifdef SPI_FE_AUTOINC_EN
                     addr_q    <= addr_q + 1'b1;
                     wdone_q   <= 1'b1;
`else
                     state_q   <= DONE;
`endif
                  end
                  RDATA: begin
`ifdef SPI_FE_AUTOINC_EN
                     rd_req_q  <= 1'b1;
                     rd_addr_q <= addr_q + 1'b1;
                     addr_q    <= addr_q + 1'b1;
`else
                     state_q   <= DONE;
`endif
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign miso      = (state_q == RDATA) & sout_q[DATA_W-1];
   assign busy      = (state_q != IDLE);
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Directed bench for spi_cmd_frontend: host-level SPI driver, frame model, scoreboard.
// Model follows SPI_FE_AUTOINC_EN when the macro is defined.
module tb_spi_cmd_frontend;

   localparam int H = 6;
`ifdef SPI_FE_AUTOINC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_req;
   logic [2:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       busy;
   logic       frame_err;

   always #5 clk = ~clk;

   spi_cmd_frontend #(
      .ADDR_W(3),
      .DATA_W(8),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sclk(sclk),
      .cs(cs),
      .mosi(mosi),
      .miso(miso),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy),
      .frame_err(frame_err)
   );

   logic [7:0] mem [8] = '{8'h81, 8'h42, 8'hC3, 8'h24,
                           8'h99, 8'h6E, 8'hF0, 8'h0F};

   int n_chk = 0;
   int n_fail = 0;

   logic [10:0] exp_wr[$];
   logic [10:0] obs_wr[$];
   logic [2:0]  exp_rd[$];
   logic [2:0]  obs_rd[$];
   int          exp_err = 0;
   int          obs_err = 0;

   logic [2:0]  last_wr_addr = '0;
   logic [7:0]  last_wr_data = '0;
   logic [2:0]  last_rd_addr = '0;
   logic        prev_wr = 1'b0;
   logic        prev_rd = 1'b0;
   logic        prev_err = 1'b0;

   int          m_n = 0;
   int          m_part = 0;
   bit          m_ign = 1'b0;
   logic [7:0]  m_cmd = '0;
   logic [7:0]  rx_last = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // observes strobes every cycle and acts as the register file for reads
   always @(negedge clk) begin
      if (wr_en) begin
         obs_wr.push_back({wr_addr, wr_data});
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
         chk("wr_pulse_len", {31'd0, prev_wr}, 0);
      end
      if (rd_req) begin
         obs_rd.push_back(rd_addr);
         last_rd_addr = rd_addr;
         rd_data = mem[rd_addr];
         chk("rd_pulse_len", {31'd0, prev_rd}, 0);
      end
      if (wr_en || rd_req)
         chk("wr_rd_exclusive", {31'd0, wr_en & rd_req}, 0);
      if (frame_err) begin
         obs_err++;
         chk("err_pulse_len", {31'd0, prev_err}, 0);
      end
      prev_wr  = wr_en;
      prev_rd  = rd_req;
      prev_err = frame_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_sb();
      chk("wr_count", obs_wr.size(), exp_wr.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0)
         chk("wr_addr_data", {21'd0, obs_wr.pop_front()},
             {21'd0, exp_wr.pop_front()});
      chk("rd_count", obs_rd.size(), exp_rd.size());
      while (obs_rd.size() > 0 && exp_rd.size() > 0)
         chk("rd_addr", {29'd0, obs_rd.pop_front()},
             {29'd0, exp_rd.pop_front()});
      chk("frame_err_count", obs_err, exp_err);
      obs_wr.delete();
      exp_wr.delete();
      obs_rd.delete();
      exp_rd.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input logic [7:0] rx);
      logic [2:0] a;
      bit         live;
      if (m_n == 0) begin
         m_cmd = b;
         chk("miso_cmd", {24'd0, rx}, 0);
         if (!b[7])
            exp_rd.push_back(b[2:0]);
      end else begin
         a = m_cmd[2:0] + 3'(m_n - 1);
         live = AI || (m_n == 1);
         if (m_cmd[7]) begin
            if (live)
               exp_wr.push_back({a, b});
            chk("miso_wr", {24'd0, rx}, 0);
         end else begin
            chk("miso_rd", {24'd0, rx}, live ? {24'd0, mem[a]} : 0);
            if (AI)
               exp_rd.push_back(a + 3'd1);
         end
      end
      rx_last = rx;
      m_n++;
   endtask

   task automatic cs_lo();
      cs = 1'b0;
      m_n = 0;
      m_part = 0;
      tick(8);
   endtask

   task automatic xfer(input logic [7:0] b, input int n);
      logic [7:0] rx;
      rx = '0;
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         tick(H);
         rx = {rx[6:0], miso};
         if (i == 0)
            chk("busy_in_frame", {31'd0, busy}, {31'd0, !m_ign});
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
      end
      if (!m_ign) begin
         if (n < 8)
            m_part = n;
         else
            model_byte(b, rx);
      end
   endtask

   task automatic cs_hi();
      tick(H);
      cs = 1'b1;
      if (!m_ign && (m_part != 0 || (m_n == 1 && m_cmd[7])))
         exp_err++;
      m_ign = 1'b0;
      tick(12);
      chk("busy_idle", {31'd0, busy}, 0);
      check_sb();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_miso"}, {31'd0, miso}, 0);
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
      chk({tag, "_rd_req"}, {31'd0, rd_req}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_frame_err"}, {31'd0, frame_err}, 0);
      chk({tag, "_addrs"}, {26'd0, wr_addr, rd_addr}, 0);
      chk({tag, "_wr_data"}, {24'd0, wr_data}, 0);
   endtask

   initial begin
      tick(5);
      chk_outputs_zero("in_reset");
      reset = 1'b1;
      tick(20);
      chk_outputs_zero("post_reset");
      check_sb();

      cs_lo();
      xfer(8'h83, 8);
      xfer(8'h5A, 8);
      cs_hi();
      chk("write_addr_lit", {29'd0, last_wr_addr}, 3);
      chk("write_data_lit", {24'd0, last_wr_data}, 32'h5A);

      cs_lo();
      xfer(8'h02, 8);
      xfer(8'h00, 8);
      cs_hi();
      chk("read_addr_lit", {29'd0, last_rd_addr}, 2);
      chk("read_miso_lit", {24'd0, rx_last}, 32'hC3);

      cs_lo();
      xfer(8'h81, 8);
      xfer(8'hFF, 5);
      cs_hi();
      chk("abort_err_lit", obs_err, 1);
      cs_lo();
      xfer(8'h81, 8);
      xfer(8'h10, 8);
      cs_hi();
      chk("retry_addr_lit", {29'd0, last_wr_addr}, 1);
      chk("retry_data_lit", {24'd0, last_wr_data}, 32'h10);

      cs_lo();
      xfer(8'h05, 8);
      xfer(8'h00, 4);
      check_sb();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      m_ign = 1'b1;
      tick(3);
      reset = 1'b1;
      xfer(8'h00, 4);
      xfer(8'h84, 8);
      cs_hi();
      cs_lo();
      xfer(8'h04, 8);
      xfer(8'h00, 8);
      cs_hi();
      chk("after_reset_miso_lit", {24'd0, rx_last}, 32'h99);

      cs_lo();
      xfer(8'h86, 8);
      xfer(8'h11, 8);
      xfer(8'h22, 8);
      xfer(8'h33, 8);
      cs_hi();
      chk("burst_last_addr_lit", {29'd0, last_wr_addr}, AI ? 0 : 6);
      chk("burst_last_data_lit", {24'd0, last_wr_data}, AI ? 32'h33 : 32'h11);

      cs_lo();
      xfer(8'h06, 8);
      xfer(8'h00, 8);
      xfer(8'h00, 8);
      xfer(8'h00, 8);
      cs_hi();
      chk("rd_burst_last_miso_lit", {24'd0, rx_last}, AI ? 32'h81 : 0);

      cs_lo();
      xfer(8'h87, 8);
      xfer(8'hA5, 8);
      cs_hi();
      chk("addr7_lit", {29'd0, last_wr_addr}, 7);

      cs_lo();
      cs_hi();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
